// File: rtl/keccak_shake_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : keccak_shake_ctrl
// Brief    : Job sequencer for a SHAKE128/SHAKE256 run. Drives the Keccak
//            state-buffer strobes through clear, absorb, 24-round permute,
//            output-buffer load and squeeze, and supplies the round index to
//            the combinational single-round core.
// Revision : 1.0 - initial release
// ============================================================================
module keccak_shake_ctrl #(
    parameter int ROUNDS  = 24,
    parameter int RATE128 = 21,
    parameter int RATE256 = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rate_sel,
    input  logic [7:0]  n_in_blocks,
    input  logic [15:0] n_out_words,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        buf_clr,
    output logic        buf_din_wen,
    output logic        buf_we_state_in,
    output logic [4:0]  round_idx,
    output logic        buf_we_output_buffer,
    output logic        buf_shift_output_buffer,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [4:0] c_LAST_ROUND  = 5'(ROUNDS - 1);
    localparam logic [4:0] c_RATE128_M1  = 5'(RATE128 - 1);
    localparam logic [4:0] c_RATE256_M1  = 5'(RATE256 - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLR     = 3'd1,
        S_ABSORB  = 3'd2,
        S_PERM    = 3'd3,
        S_LOAD    = 3'd4,
        S_SQUEEZE = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Job parameters latched on an accepted start; rate stored as R-1
    logic [4:0]  r_rate_m1;
    logic [7:0]  r_n_blocks;
    logic [15:0] r_n_words;

    // Progress counters
    logic [4:0]  r_wcnt;
    logic [7:0]  r_bcnt;
    logic [4:0]  r_ocnt;
    logic [15:0] r_total;
    logic [4:0]  r_round;

    // Registered strobes
    logic        r_in_ready;
    logic        r_clr;
    logic        r_we_state_in;
    logic        r_we_output_buffer;
    logic        r_out_valid;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic        w_start_ok;
    logic [15:0] w_total_inc;
    logic        w_last_word;

    assign w_start_ok  = (n_in_blocks != 8'd0) && (n_out_words != 16'd0);
    assign w_total_inc = r_total + 16'd1;
    assign w_last_word = (w_total_inc == r_n_words);

    // Next-state selection; counters and strobes are registered from it below
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (start && w_start_ok) w_state_nxt = S_CLR;
            S_CLR:     w_state_nxt = S_ABSORB;
            S_ABSORB: begin
                if (in_valid) begin
                    if (r_wcnt == r_rate_m1) w_state_nxt = S_PERM;
                end else if (r_wcnt != 5'd0) begin
                    // A block must arrive back to back; a hole aborts the job
                    w_state_nxt = S_IDLE;
                end
            end
            S_PERM: begin
                // Absorb-side and refill permutations share this exit: once all
                // blocks are in, bcnt stays equal to the block count.
                if (r_round == c_LAST_ROUND)
                    w_state_nxt = (r_bcnt < r_n_blocks) ? S_ABSORB : S_LOAD;
            end
            S_LOAD:    w_state_nxt = S_SQUEEZE;
            S_SQUEEZE: begin
                if (out_ready) begin
                    if (w_last_word)                w_state_nxt = S_IDLE;
                    else if (r_ocnt == r_rate_m1)   w_state_nxt = S_PERM;
                end
            end
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // State register, job counters and registered per-state strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state            <= S_IDLE;
            r_rate_m1          <= 5'd0;
            r_n_blocks         <= 8'd0;
            r_n_words          <= 16'd0;
            r_wcnt             <= 5'd0;
            r_bcnt             <= 8'd0;
            r_ocnt             <= 5'd0;
            r_total            <= 16'd0;
            r_round            <= 5'd0;
            r_in_ready         <= 1'b0;
            r_clr              <= 1'b0;
            r_we_state_in      <= 1'b0;
            r_we_output_buffer <= 1'b0;
            r_out_valid        <= 1'b0;
            r_busy             <= 1'b0;
            r_done             <= 1'b0;
            r_err              <= 1'b0;
        end else begin
            r_state            <= w_state_nxt;
            r_in_ready         <= (w_state_nxt == S_ABSORB);
            r_clr              <= (w_state_nxt == S_CLR);
            r_we_state_in      <= (w_state_nxt == S_PERM);
            r_we_output_buffer <= (w_state_nxt == S_LOAD);
            r_out_valid        <= (w_state_nxt == S_SQUEEZE);
            r_busy             <= (w_state_nxt != S_IDLE);
            r_done             <= (r_state == S_SQUEEZE) && (w_state_nxt == S_IDLE);
            r_round            <= ((r_state == S_PERM) && (w_state_nxt == S_PERM))
                                  ? r_round + 5'd1 : 5'd0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_start_ok) begin
                            r_err      <= 1'b0;
                            r_rate_m1  <= rate_sel ? c_RATE256_M1 : c_RATE128_M1;
                            r_n_blocks <= n_in_blocks;
                            r_n_words  <= n_out_words;
                            r_total    <= 16'd0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_CLR: begin
                    r_wcnt <= 5'd0;
                    r_bcnt <= 8'd0;
                end
                S_ABSORB: begin
                    if (in_valid) begin
                        if (r_wcnt == r_rate_m1) begin
                            r_wcnt <= 5'd0;
                            r_bcnt <= r_bcnt + 8'd1;
                        end else begin
                            r_wcnt <= r_wcnt + 5'd1;
                        end
                    end else if (r_wcnt != 5'd0) begin
                        r_err <= 1'b1;
                    end
                end
                S_LOAD: r_ocnt <= 5'd0;
                S_SQUEEZE: begin
                    if (out_ready) begin
                        r_ocnt  <= r_ocnt + 5'd1;
                        r_total <= w_total_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready                = r_in_ready;
    assign buf_clr                 = r_clr;
    assign buf_din_wen             = in_valid & r_in_ready;
    assign buf_we_state_in         = r_we_state_in;
    assign round_idx               = r_round;
    assign buf_we_output_buffer    = r_we_output_buffer;
    assign buf_shift_output_buffer = r_out_valid & out_ready;
    assign out_valid               = r_out_valid;
    assign busy                    = r_busy;
    assign done                    = r_done;
    assign err                     = r_err;

endmodule
`default_nettype wire
